// File: rtl/present_key_sched_ctrl_if.sv
// Key-load handshake, status and round-key read port for the PRESENT key-schedule engine.
// The master side loads keys and reads round keys; the slave side is the engine.
interface present_key_sched_ctrl_if #(
    parameter int unsigned KEY_SIZE = 80,
    parameter int unsigned RK_W     = 64
);
    logic                key_valid;
    logic                key_ready;
    logic [KEY_SIZE-1:0] key_in;
    logic                abort;
    logic                busy;
    logic                done;
    logic [5:0]          rk_count;
    logic                rk_rd_en;
    logic [4:0]          rk_rd_idx;
    logic [RK_W-1:0]     rk_rd_data;
    logic                rk_rd_err;

    modport master (
        output key_valid, key_in, abort, rk_rd_en, rk_rd_idx,
        input  key_ready, busy, done, rk_count, rk_rd_data, rk_rd_err
    );

    modport slave (
        input  key_valid, key_in, abort, rk_rd_en, rk_rd_idx,
        output key_ready, busy, done, rk_count, rk_rd_data, rk_rd_err
    );
endinterface

// File: rtl/present_key_sched_ctrl.sv
// Sequential PRESENT key schedule: one key-register update per clock.
// Each round key goes into a store with a registered read port.
module present_key_sched_ctrl #(
    parameter int unsigned KEY_SIZE   = 80,
    parameter int unsigned NUM_ROUNDS = 31,
    parameter int unsigned RK_W       = 64
) (
    input logic                     clk,
    input logic                     rst_n,
    present_key_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGen, StReady} state_e;

    localparam logic [4:0]  LastRc  = 5'(NUM_ROUNDS);
    // Nibble i of this constant is S(i).
    localparam logic [63:0] SboxTbl = 64'h21748FE3DA09B65C;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SboxTbl[{x, 2'b00} +: 4];
    endfunction

    state_e              state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d, key_rot, key_next;
    logic [4:0]          rc_q, rc_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [4:0]          wr_idx;
    logic [RK_W-1:0]     wr_data;
    logic [RK_W-1:0]     rd_data_q;
    logic                rd_err_q;
    logic [RK_W-1:0]     store [0:NUM_ROUNDS];

    assign key_rot = {key_q[KEY_SIZE-62:0], key_q[KEY_SIZE-1:KEY_SIZE-61]};

    if (KEY_SIZE == 80) begin : g_k80
        assign key_next = {sbox(key_rot[79:76]), key_rot[75:20],
                           key_rot[19:15] ^ rc_q, key_rot[14:0]};
    end else if (KEY_SIZE == 128) begin : g_k128
        assign key_next = {sbox(key_rot[127:124]), sbox(key_rot[123:120]), key_rot[119:67],
                           key_rot[66:62] ^ rc_q, key_rot[61:0]};
    end else begin : g_bad
        $error("present_key_sched_ctrl: KEY_SIZE must be 80 or 128");
        assign key_next = key_rot;
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = rc_q;
        wr_data = key_next[KEY_SIZE-1 -: RK_W];
        unique case (state_q)
            StIdle, StReady: begin
                // Abort beats a simultaneous key handshake.
                if (bus.abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (bus.key_valid) begin
                    state_d = StGen;
                    key_d   = bus.key_in;
                    rc_d    = 5'd1;
                    cnt_d   = 6'd1;
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    wr_data = bus.key_in[KEY_SIZE-1 -: RK_W];
                end
            end
            StGen: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    wr_en = 1'b1;
                    key_d = key_next;
                    cnt_d = {1'b0, rc_q} + 6'd1;
                    if (rc_q == LastRc) begin
                        state_d = StReady;
                        done_d  = 1'b1;
                    end else begin
                        rc_d = rc_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Store contents are qualified by rk_count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else if (bus.rk_rd_en) begin
            if ({1'b0, bus.rk_rd_idx} >= cnt_q) begin
                rd_data_q <= '0;
                rd_err_q  <= 1'b1;
            end else begin
                rd_data_q <= store[bus.rk_rd_idx];
                rd_err_q  <= 1'b0;
            end
        end
    end

    assign bus.key_ready  = (state_q != StGen);
    assign bus.busy       = (state_q == StGen);
    assign bus.done       = done_q;
    assign bus.rk_count   = cnt_q;
    assign bus.rk_rd_data = rd_data_q;
    assign bus.rk_rd_err  = rd_err_q;
endmodule

// File: doc/present_key_sched_ctrl.md
Name: present_key_sched_ctrl

Overview:
- Sequential PRESENT key-schedule engine. Accepts a cipher key over a valid/ready handshake, then iterates the key-register update once per clock.
- Each round key is written into an internal round-key store as it is produced.
- The round datapath reads keys through a registered read port. It can begin consuming keys before generation finishes by watching rk_count.

Parameters:
- KEY_SIZE, 80, cipher key width. Legal values are 80 and 128 only; any other value is an elaboration error.
- NUM_ROUNDS, 31, number of cipher rounds. The block stores NUM_ROUNDS+1 round keys.
- RK_W, 64, round-key width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  block accepts a key this cycle.
- key_in  in  KEY_SIZE  cipher key.
- abort  in  1  cancel the current generation and return to IDLE.
- busy  out  1  high while in GEN.
- done  out  1  one-cycle pulse when the last round key has been written.
- rk_count  out  6  number of valid round keys in the store, 0..NUM_ROUNDS+1.
- rk_rd_en  in  1  read request.
- rk_rd_idx  in  5  round-key index to read, 0..NUM_ROUNDS.
- rk_rd_data  out  RK_W  read data; valid 1 cycle after rk_rd_en.
- rk_rd_err  out  1  the read addressed an index >= rk_count; same timing as rk_rd_data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; key register, rk_count, done, busy, rk_rd_data and rk_rd_err all clear to 0.
  - Store contents need not be cleared, but rk_count=0 marks them invalid.
  - key_ready=1 in the first cycle after reset deassertion.
- States: IDLE, GEN, READY.
- key_ready=1 in IDLE and READY; key_ready=0 in GEN.
- Handshake and load (key_valid & key_ready at a clock edge):
  - key register <= key_in; store[0] <= key_in[KEY_SIZE-1 -: 64]; rk_count <= 1; round counter rc <= 1; next state GEN.
  - A load in READY overwrites the previous schedule, so rk_count restarts at 1.
- GEN, once per cycle:
  - next = update(key, rc); key <= next; store[rc] <= next[KEY_SIZE-1 -: 64]; rk_count <= rc+1; rc <= rc+1.
  - When rc == NUM_ROUNDS: write store[31], pulse done for one cycle, set rk_count=32, go to READY.
  - Latency: load edge to done pulse is NUM_ROUNDS cycles (31). rk_count becomes k+1 the cycle after store[k] is written.
- update() for KEY_SIZE=80:
  - Rotate left by 61.
  - Top nibble [79:76] <= S(nibble).
  - [19:15] ^= rc[4:0].
- update() for KEY_SIZE=128:
  - Rotate left by 61.
  - [127:124] <= S, [123:120] <= S.
  - [66:62] ^= rc[4:0].
- S-box, inputs 0..F map to: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- rc is 5 bits and ranges 1..31 only; it never wraps, and values of 0 or >31 are never used.
- abort:
  - In GEN: the next state is IDLE, rk_count <= 0, and done is not pulsed.
  - In READY: the schedule is invalidated and the block goes to IDLE.
  - Abort and a key handshake in the same cycle: abort wins and the key is not accepted.
  - Abort in IDLE has no effect.
- Read port:
  - Synchronous, 1-cycle latency. rk_rd_data is registered and holds its value when rk_rd_en=0.
  - Reads are allowed in any state.
  - If rk_rd_idx >= rk_count (sampled at the request edge): rk_rd_data=0 and rk_rd_err=1. Otherwise rk_rd_err=0.
  - Reading index k in the same cycle store[k] is being written returns err=1, because rk_count has not yet advanced.
- busy=1 exactly while in GEN.
- done is a registered pulse, asserted in the cycle after the final write edge.

Test Plan:
- Reset mid-GEN: load a key, assert rst_n=0 at cycle 10 -> rk_count=0, busy=0, key_ready=1 after release, and a read of idx 0 returns err=1.
- KEY_SIZE=80, key=0:
  - rk[0] = 0x0000000000000000.
  - rk[1] = 0xC000000000000000.
  - rk[2] = 0x5000180000000001.
  - done pulses exactly 31 cycles after the load edge; rk_count=32.
- Full schedule check: random 80-bit and 128-bit keys, read idx 0..31 after done -> every value matches the reference-model schedule, with err=0 throughout.
- Early consumption: issue reads of idx k whenever rk_count > k during GEN -> correct data, never err. Then read idx 5 while rk_count=5 -> data 0, err=1.
- Abort at cycle 15 of GEN, together with key_valid=1 -> no done pulse, IDLE, rk_count=0, key not accepted. A new load on the next cycle completes normally.
- Reload in READY: load key A, wait for done, then load key B in the first READY cycle -> rk_count=1, busy=1, and a final rk[31] matching key B.
